// File: rtl/regfile_mp_pkg.sv
// Shared constants, types and helpers for the multi-port register file.
// Optional feature macro used by the top: REGFILE_MP_BYPASS_EN.
package regfile_mp_pkg;

    localparam int DEF_ADDRESS_WIDTH = 5;
    localparam int DEF_DATA_WIDTH    = 32;
    localparam int ZERO_REG          = 0;

    // Upper bounds for the generic slice helper: 4 ports x 64-bit data.
    localparam int MAX_VEC_W   = 256;
    localparam int MAX_SLICE_W = 64;

    typedef logic [DEF_ADDRESS_WIDTH-1:0] reg_addr_t;

    // Returns slice idx (each slice `width` bits) of a packed port vector.
    // Callers zero-extend the vector to MAX_VEC_W and truncate the result.
    function automatic logic [MAX_SLICE_W-1:0] get_slice(
        input logic [MAX_VEC_W-1:0] vec,
        input int                   idx,
        input int                   width
    );
        logic [MAX_VEC_W-1:0] shifted;
        logic [MAX_VEC_W-1:0] mask;
        shifted = vec >> (idx * width);
        mask    = (MAX_VEC_W'(1) << width) - MAX_VEC_W'(1);
        return MAX_SLICE_W'(shifted & mask);
    endfunction

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// Per-register busy bits. A set marks a new producer in flight; an accepted
// write retires it. When both hit the same register on one edge the set wins,
// since the set belongs to a newer producer than the write being retired.
// Register 0 can never be set, so its bit stays 0 from reset onward.
module regfile_mp_scoreboard
    import regfile_mp_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int DEPTH         = 2 ** ADDRESS_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     set_en,
    input  logic [ADDRESS_WIDTH-1:0] set_addr,
    input  logic [DEPTH-1:0]         clr,
    output logic [DEPTH-1:0]         busy
);

    logic [DEPTH-1:0] busy_next;

    // Next busy vector: set beats clear, clear beats hold.
    always_comb begin
        busy_next = busy;
        for (int a = 0; a < DEPTH; a++) begin
            if (set_en && (a != ZERO_REG) && (set_addr == ADDRESS_WIDTH'(a))) begin
                busy_next[a] = 1'b1;
            end else if (clr[a]) begin
                busy_next[a] = 1'b0;
            end
        end
    end

    // Busy register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with hardwired-zero x0, debug tap on a0 and a
// busy scoreboard for decode stalls.
// Build option: define REGFILE_MP_BYPASS_EN for same-cycle write-through
// forwarding on RD, RB and a0; without it reads show the stored contents.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int NUM_READ      = 2,
    parameter int NUM_WRITE     = 2,
    parameter int TAP_ADDR      = 10
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_READ*ADDRESS_WIDTH-1:0]  AD_R,
    output logic [NUM_READ*DATA_WIDTH-1:0]     RD,
    output logic [NUM_READ-1:0]                RB,
    input  logic [NUM_WRITE-1:0]               WE,
    input  logic [NUM_WRITE*ADDRESS_WIDTH-1:0] AD_W,
    input  logic [NUM_WRITE*DATA_WIDTH-1:0]    WD,
    input  logic                               SB_SET,
    input  logic [ADDRESS_WIDTH-1:0]           SB_AD,
    output logic [DATA_WIDTH-1:0]              a0
);

    localparam int DEPTH = 2 ** ADDRESS_WIDTH;

    if (NUM_READ < 1 || NUM_READ > 4) begin : g_bad_num_read
        $error("regfile_mp: NUM_READ must be 1..4");
    end
    if (NUM_WRITE < 1 || NUM_WRITE > 2) begin : g_bad_num_write
        $error("regfile_mp: NUM_WRITE must be 1..2");
    end
    if (DATA_WIDTH > MAX_SLICE_W || NUM_READ * DATA_WIDTH > MAX_VEC_W) begin : g_bad_width
        $error("regfile_mp: port vectors exceed slice helper limits");
    end
    if (TAP_ADDR < 0 || TAP_ADDR >= DEPTH) begin : g_bad_tap
        $error("regfile_mp: TAP_ADDR outside register range");
    end

    logic [DATA_WIDTH-1:0]    mem      [DEPTH];
    logic [ADDRESS_WIDTH-1:0] r_addr   [NUM_READ];
    logic [ADDRESS_WIDTH-1:0] w_addr   [NUM_WRITE];
    logic [DATA_WIDTH-1:0]    w_data   [NUM_WRITE];
    logic                     wr_hit   [DEPTH];
    logic [DATA_WIDTH-1:0]    wr_data  [DEPTH];
    logic [DEPTH-1:0]         wr_clr;
    logic [DEPTH-1:0]         busy;

    // Unpack the flat port vectors into per-port addresses and data.
    always_comb begin
        for (int i = 0; i < NUM_READ; i++) begin
            r_addr[i] = ADDRESS_WIDTH'(get_slice(MAX_VEC_W'(AD_R), i, ADDRESS_WIDTH));
        end
        for (int j = 0; j < NUM_WRITE; j++) begin
            w_addr[j] = ADDRESS_WIDTH'(get_slice(MAX_VEC_W'(AD_W), j, ADDRESS_WIDTH));
            w_data[j] = DATA_WIDTH'(get_slice(MAX_VEC_W'(WD), j, DATA_WIDTH));
        end
    end

    // Write arbitration per register: later ports override earlier ones, x0 never accepts.
    always_comb begin
        for (int a = 0; a < DEPTH; a++) begin
            wr_hit[a]  = 1'b0;
            wr_data[a] = '0;
        end
        for (int j = 0; j < NUM_WRITE; j++) begin
            if (WE[j] && (w_addr[j] != ADDRESS_WIDTH'(ZERO_REG))) begin
                wr_hit[w_addr[j]]  = 1'b1;
                wr_data[w_addr[j]] = w_data[j];
            end
        end
        for (int a = 0; a < DEPTH; a++) begin
            wr_clr[a] = wr_hit[a];
        end
    end

    // Storage array; x0 is only ever loaded by reset so it stays zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int a = 0; a < DEPTH; a++) begin
                mem[a] <= '0;
            end
        end else begin
            for (int a = 1; a < DEPTH; a++) begin
                if (wr_hit[a]) begin
                    mem[a] <= wr_data[a];
                end
            end
        end
    end

    regfile_mp_scoreboard #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DEPTH         (DEPTH)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (SB_SET),
        .set_addr (SB_AD),
        .clr      (wr_clr),
        .busy     (busy)
    );

    logic [ADDRESS_WIDTH-1:0] tap_addr;
    assign tap_addr = ADDRESS_WIDTH'(TAP_ADDR);

    // Read muxes, tap and busy outputs, with optional write-through forwarding.
    always_comb begin
        logic [ADDRESS_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0]    rd_val;
        logic                     rb_val;
        logic                     fwd;
        RD     = '0;
        RB     = '0;
        a0     = '0;
        ra     = '0;
        rd_val = '0;
        rb_val = 1'b0;
        fwd    = 1'b0;
        for (int i = 0; i < NUM_READ; i++) begin
            ra     = r_addr[i];
            rd_val = (ra == ADDRESS_WIDTH'(ZERO_REG)) ? '0 : mem[ra];
            rb_val = busy[ra];
            fwd    = 1'b0;
`ifdef REGFILE_MP_BYPASS_EN
            // Forwarding is held off during reset so outputs read zero.
            for (int j = 0; j < NUM_WRITE; j++) begin
                if (rst_n && WE[j] && (w_addr[j] == ra) && (ra != ADDRESS_WIDTH'(ZERO_REG))) begin
                    rd_val = w_data[j];
                    fwd    = 1'b1;
                end
            end
            if (fwd && !(SB_SET && (SB_AD == ra))) begin
                rb_val = 1'b0;
            end
`endif
            RD[i*DATA_WIDTH +: DATA_WIDTH] = rd_val;
            RB[i]                          = rb_val;
        end
        a0 = (tap_addr == ADDRESS_WIDTH'(ZERO_REG)) ? '0 : mem[tap_addr];
`ifdef REGFILE_MP_BYPASS_EN
        for (int j = 0; j < NUM_WRITE; j++) begin
            if (rst_n && WE[j] && (w_addr[j] == tap_addr) && (tap_addr != ADDRESS_WIDTH'(ZERO_REG))) begin
                a0 = w_data[j];
            end
        end
`endif
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a default 2R/2W instance plus a narrow
// 4R/1W instance. Expectations adapt to REGFILE_MP_BYPASS_EN.
module tb_regfile_mp;

    logic        clk;
    logic        rst_n;
    logic [9:0]  AD_R;
    logic [63:0] RD;
    logic [1:0]  RB;
    logic [1:0]  WE;
    logic [9:0]  AD_W;
    logic [63:0] WD;
    logic        SB_SET;
    logic [4:0]  SB_AD;
    logic [31:0] a0;

    logic [11:0] s_ad_r;
    logic [31:0] s_rd;
    logic [3:0]  s_rb;
    logic [0:0]  s_we;
    logic [2:0]  s_ad_w;
    logic [7:0]  s_wd;
    logic        s_sb_set;
    logic [2:0]  s_sb_ad;
    logic [7:0]  s_a0;

    int n_pass  = 0;
    int n_total = 0;

`ifdef REGFILE_MP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    regfile_mp u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .AD_R   (AD_R),
        .RD     (RD),
        .RB     (RB),
        .WE     (WE),
        .AD_W   (AD_W),
        .WD     (WD),
        .SB_SET (SB_SET),
        .SB_AD  (SB_AD),
        .a0     (a0)
    );

    regfile_mp #(
        .ADDRESS_WIDTH (3),
        .DATA_WIDTH    (8),
        .NUM_READ      (4),
        .NUM_WRITE     (1),
        .TAP_ADDR      (7)
    ) u_sweep (
        .clk    (clk),
        .rst_n  (rst_n),
        .AD_R   (s_ad_r),
        .RD     (s_rd),
        .RB     (s_rb),
        .WE     (s_we),
        .AD_W   (s_ad_w),
        .WD     (s_wd),
        .SB_SET (s_sb_set),
        .SB_AD  (s_sb_ad),
        .a0     (s_a0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  aw0;
        logic [31:0] wd0;
        logic [4:0]  aw1;
        logic [31:0] wd1;
        logic        sb;
        logic [4:0]  sba;
        logic [4:0]  ar0;
        logic [4:0]  ar1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic        eb0;
        logic        eb1;
        logic [31:0] ea0;
    } vec_t;

    vec_t vt[9];

    initial begin
        vt[0] = '{2'b11, 5'd5, 32'hDEADBEEF, 5'd0, 32'h12345678, 1'b0, 5'd0, 5'd5, 5'd0,
                  32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 32'h0};
        vt[1] = '{2'b11, 5'd7, 32'h1111, 5'd7, 32'h2222, 1'b0, 5'd0, 5'd7, 5'd5,
                  32'h2222, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
        vt[2] = '{2'b01, 5'd1, 32'hCAFE, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd1,
                  32'h0, 32'hCAFE, 1'b1, 1'b0, 32'h0};
        vt[3] = '{2'b10, 5'd0, 32'h0, 5'd3, 32'h55, 1'b0, 5'd0, 5'd3, 5'd3,
                  32'h55, 32'h55, 1'b0, 1'b0, 32'h0};
        vt[4] = '{2'b01, 5'd3, 32'h66, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd7,
                  32'h66, 32'h2222, 1'b1, 1'b0, 32'h0};
        vt[5] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd3,
                  32'h0, 32'h66, 1'b0, 1'b1, 32'h0};
        vt[6] = '{2'b10, 5'd2, 32'hBAD, 5'd31, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd31, 5'd2,
                  32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 32'h0};
        vt[7] = '{2'b01, 5'd0, 32'h999, 5'd0, 32'h0, 1'b1, 5'd31, 5'd0, 5'd31,
                  32'h0, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h0};
        vt[8] = '{2'b01, 5'd10, 32'hA5A5A5A5, 5'd0, 32'h0, 1'b0, 5'd0, 5'd10, 5'd3,
                  32'hA5A5A5A5, 32'h66, 1'b0, 1'b1, 32'hA5A5A5A5};

        rst_n  = 1'b0;
        AD_R   = '0;
        WE     = '0;
        AD_W   = '0;
        WD     = '0;
        SB_SET = 1'b0;
        SB_AD  = '0;
        s_ad_r = '0;
        s_we   = '0;
        s_ad_w = '0;
        s_wd   = '0;
        s_sb_set = 1'b0;
        s_sb_ad  = '0;

        // Reset contents
        tick();
        tick();
        check("a0_in_reset", 64'(a0), 64'h0);
        rst_n = 1'b1;
        tick();
        for (int a = 0; a < 32; a++) begin
            AD_R = {5'(a), 5'(a)};
            #1;
            check("rst_rd0", 64'(RD[31:0]), 64'h0);
            check("rst_rd1", 64'(RD[63:32]), 64'h0);
            check("rst_rb", 64'(RB), 64'h0);
        end
        check("rst_a0", 64'(a0), 64'h0);

        // Table-driven write/read/scoreboard vectors
        for (int v = 0; v < 9; v++) begin
            WE     = vt[v].we;
            AD_W   = {vt[v].aw1, vt[v].aw0};
            WD     = {vt[v].wd1, vt[v].wd0};
            SB_SET = vt[v].sb;
            SB_AD  = vt[v].sba;
            tick();
            WE     = '0;
            SB_SET = 1'b0;
            AD_R   = {vt[v].ar1, vt[v].ar0};
            #1;
            check($sformatf("v%0d_rd0", v), 64'(RD[31:0]), 64'(vt[v].e0));
            check($sformatf("v%0d_rd1", v), 64'(RD[63:32]), 64'(vt[v].e1));
            check($sformatf("v%0d_rb0", v), 64'(RB[0]), 64'(vt[v].eb0));
            check($sformatf("v%0d_rb1", v), 64'(RB[1]), 64'(vt[v].eb1));
            check($sformatf("v%0d_a0", v), 64'(a0), 64'(vt[v].ea0));
        end

        // Scoreboard clear timing against a write
        tick();
        SB_SET = 1'b1;
        SB_AD  = 5'd4;
        tick();
        SB_SET = 1'b0;
        AD_R   = {5'd4, 5'd4};
        #1;
        check("sb4_set_rb", 64'(RB[0]), 64'h1);
        WE   = 2'b01;
        AD_W = {5'd0, 5'd4};
        WD   = {32'h0, 32'h77};
        #1;
        check("sb4_pre_rd", 64'(RD[31:0]), BYP ? 64'h77 : 64'h0);
        check("sb4_pre_rb", 64'(RB[0]), BYP ? 64'h0 : 64'h1);
        tick();
        WE = '0;
        #1;
        check("sb4_post_rd", 64'(RD[31:0]), 64'h77);
        check("sb4_post_rb", 64'(RB[0]), 64'h0);

        // Both ports to x8: forwarding and storage both pick the higher port
        WE   = 2'b11;
        AD_W = {5'd8, 5'd8};
        WD   = {32'hBBBB, 32'hAAAA};
        AD_R = {5'd8, 5'd0};
        #1;
        check("x8_pre_rd1", 64'(RD[63:32]), BYP ? 64'hBBBB : 64'h0);
        check("x8_pre_rd0", 64'(RD[31:0]), 64'h0);
        tick();
        WE = '0;
        #1;
        check("x8_post_rd1", 64'(RD[63:32]), 64'hBBBB);

        // Set and write of x9 on one edge: busy survives
        WE     = 2'b01;
        AD_W   = {5'd0, 5'd9};
        WD     = {32'h0, 32'h9};
        SB_SET = 1'b1;
        SB_AD  = 5'd9;
        AD_R   = {5'd0, 5'd9};
        #1;
        check("x9_pre_rd", 64'(RD[31:0]), BYP ? 64'h9 : 64'h0);
        check("x9_pre_rb", 64'(RB[0]), 64'h0);
        tick();
        WE     = '0;
        SB_SET = 1'b0;
        #1;
        check("x9_post_rd", 64'(RD[31:0]), 64'h9);
        check("x9_post_rb", 64'(RB[0]), 64'h1);

        // Tap and mid-cycle reset
        AD_R = {5'd10, 5'd31};
        #1;
        check("pre_rst_a0", 64'(a0), 64'hA5A5A5A5);
        check("pre_rst_rd0", 64'(RD[31:0]), 64'hFFFFFFFF);
        check("pre_rst_rb0", 64'(RB[0]), 64'h1);
        WE     = 2'b01;
        AD_W   = {5'd0, 5'd10};
        WD     = {32'h0, 32'h1234};
        SB_SET = 1'b1;
        SB_AD  = 5'd10;
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_a0", 64'(a0), 64'h0);
        check("mid_rst_rd", RD, 64'h0);
        check("mid_rst_rb", 64'(RB), 64'h0);
        tick();
        check("rst_edge_a0", 64'(a0), 64'h0);
        WE     = '0;
        SB_SET = 1'b0;
        rst_n  = 1'b1;
        tick();
        check("after_rst_rd", RD, 64'h0);
        check("after_rst_rb", 64'(RB), 64'h0);
        check("after_rst_a0", 64'(a0), 64'h0);

        // Narrow 4R/1W instance
        s_we   = 1'b1;
        s_ad_w = 3'd7;
        s_wd   = 8'hFF;
        tick();
        s_we   = 1'b0;
        s_ad_r = {3'd7, 3'd7, 3'd7, 3'd7};
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("sw_rd%0d", i), 64'(s_rd[i*8 +: 8]), 64'hFF);
        end
        check("sw_rb", 64'(s_rb), 64'h0);
        check("sw_a0", 64'(s_a0), 64'hFF);
        s_we   = 1'b1;
        s_ad_w = 3'd0;
        s_wd   = 8'h3C;
        tick();
        s_we   = 1'b0;
        s_ad_r = {3'd7, 3'd0, 3'd7, 3'd0};
        #1;
        check("sw_x0_rd0", 64'(s_rd[7:0]), 64'h0);
        check("sw_x0_rd2", 64'(s_rd[23:16]), 64'h0);
        check("sw_x7_rd3", 64'(s_rd[31:24]), 64'hFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file that generalises the single-write, two-read CPU register file. It has a configurable number of read and write ports, a hardwired-zero register 0, asynchronous clear, a configurable debug tap (the generalised `a0` output) and a per-register busy scoreboard for stall detection. It sits between decode (reads, scoreboard set) and writeback (writes, scoreboard clear) in the pipelined core.

## Interface
Parameters:
- `ADDRESS_WIDTH`, default 5: register address width; depth is 2**ADDRESS_WIDTH.
- `DATA_WIDTH`, default 32: register width.
- `NUM_READ`, default 2: number of read ports, range 1–4.
- `NUM_WRITE`, default 2: number of write ports, range 1–2.
- `TAP_ADDR`, default 10: register driven on `a0`.

Ports:
- `clk`, input, 1: sole clock; all state is updated on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `AD_R`, input, NUM_READ*ADDRESS_WIDTH: read addresses; port i occupies slice i.
- `RD`, output, NUM_READ*DATA_WIDTH: read data; port i occupies slice i.
- `RB`, output, NUM_READ: busy flag per read port.
- `WE`, input, NUM_WRITE: write enables.
- `AD_W`, input, NUM_WRITE*ADDRESS_WIDTH: write addresses.
- `WD`, input, NUM_WRITE*DATA_WIDTH: write data.
- `SB_SET`, input, 1: mark register `SB_AD` busy.
- `SB_AD`, input, ADDRESS_WIDTH: scoreboard set address.
- `a0`, output, DATA_WIDTH: continuous view of register `TAP_ADDR`.

## Operation
- **Reset.** While `rst_n` is 0, all registers and all busy bits are 0, independent of `clk`. Consequently `RD`, `RB` and `a0` are all 0 during reset.
- **Reads.** Reads are combinational: `RD[i]` equals `reg[AD_R[i]]`. Register 0 always reads 0.
- **Writes.**
  - On a rising edge with `WE[j]` = 1, `reg[AD_W[j]]` takes `WD[j]`.
  - Writes to address 0 are discarded.
  - If both write ports target the same address, port NUM_WRITE-1 wins.
- **Scoreboard (one busy bit per register).**
  - Set: a rising edge with `SB_SET` = 1 and `SB_AD` ≠ 0 sets `busy[SB_AD]`.
  - Clear: any accepted write to address A clears `busy[A]` on the same edge.
  - Set and clear of the same address on the same edge: set wins, because a new producer has been issued.
  - `busy[0]` is constant 0.
- **Busy outputs.** `RB[i]` is `busy[AD_R[i]]`, adjusted as described in Configuration.
- **Debug tap.** `a0` is `reg[TAP_ADDR]` and follows the same bypass rule as the read ports.
- **Mid-operation reset.** Asserting `rst_n` low mid-cycle clears state immediately. No write or set from that cycle is retained.

## Timing
- Read latency is 0 cycles (combinational from `AD_R`).
- Write latency is 1 cycle: data is visible on `RD` in the cycle after the `WE` edge, or in the same cycle when bypass is enabled.
- A scoreboard set is visible on `RB` from the cycle after `SB_SET`.
- A scoreboard clear is visible on `RB` from the cycle after the write, or in the same cycle when bypass is enabled.
- There are no handshakes. The block never stalls; the consumer must stall while `RB[i]` = 1.
- Write and scoreboard-set decisions use values sampled at the `clk` rising edge. Release of `rst_n` is synchronised externally.

## Configuration
- Macro `REGFILE_MP_BYPASS_EN`.
- **Defined:** same-cycle write-through forwarding.
  - If `WE[j]` = 1, `AD_W[j]` = `AD_R[i]` ≠ 0, then `RD[i]` = `WD[j]`, with the highest j winning.
  - `RB[i]` is forced to 0 for that address unless `SB_SET` targets the same address this cycle.
  - `a0` is forwarded in the same way.
- **Undefined:** reads return the pre-edge register contents, and `RB` reflects the registered busy bits only.

## Structure
- Package `regfile_mp_pkg` holds:
  - Default width constants.
  - `ZERO_REG` = 0.
  - A typedef for the register address.
  - A function that extracts slice i from a packed port vector.
- Sub-module `regfile_mp_scoreboard` holds the busy-bit array: set/clear logic, priority rules and async reset. It exposes the `busy` vector.
- The top level holds:
  - The storage array.
  - Write-port arbitration.
  - Read muxes.
  - Bypass logic.

## Test plan
1. **Reset contents.** Hold `rst_n` = 0, then release. Read every address on every port → all `RD` = 0, all `RB` = 0, `a0` = 0.
2. **Write/read and zero register.** Write 0xDEADBEEF to x5 and 0x12345678 to x0 in the same cycle on ports 0 and 1. Next cycle, read x5 and x0 → 0xDEADBEEF and 0.
3. **Write-port conflict.** Drive both ports to x7 with 0x1111 (port 0) and 0x2222 (port 1). Next cycle read x7 → 0x2222.
4. **Scoreboard set/clear.**
   - `SB_SET` x3 → `RB` = 1 while reading x3 the next cycle.
   - Write x3 = 0x55 → `RB` = 0 and `RD` = 0x55 in the same cycle when bypass is defined, or one cycle later when it is not.
   - Set and write x3 on the same edge → `RB` stays 1.
5. **Tap and reset mid-operation.**
   - Write x10 = 0xA5A5A5A5 → `a0` = 0xA5A5A5A5.
   - Pull `rst_n` low between edges → `a0`, `RD` and `RB` drop to 0 immediately, before the next edge.
6. **Parameter sweep.** Run with NUM_READ = 4, NUM_WRITE = 1, ADDRESS_WIDTH = 3, DATA_WIDTH = 8. Write 0xFF to x7 and read it on all four ports → all four return 0xFF.
